// File: rtl/sv32_table_walk.sv
// sv32_table_walk: two-level Sv32 page-table walker returning a flattened leaf word (all-zero on fault).
module sv32_table_walk #(
  parameter bit CHECK_A = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        walk_valid,
  output logic        walk_ready,
  input  logic [31:0] address,
  input  logic [31:0] satp,
  output logic [31:0] pte_,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [33:0] mem_addr,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, L1, L0, DONE} state_t;
  state_t      state_q;
  logic        walk_ready_q, mem_valid_q;
  logic [33:0] mem_addr_q, l0_addr_d;
  logic [31:0] pte_q, pte_d;
  logic [9:0]  vpn0_q;
  logic [21:0] ppn, base;
  logic        is_ptr, bad, fault;
  assign ppn    = mem_rdata[31:10];
  assign is_ptr = mem_rdata[0] & ~mem_rdata[1] & ~mem_rdata[2] & ~mem_rdata[3];
  assign bad    = ~mem_rdata[0] | (mem_rdata[2] & ~mem_rdata[1]);
  // A level-1 leaf is a superpage: low PPN bits come from VPN[0] and must be zero in the PTE.
  assign base   = (state_q == L1) ? {ppn[21:10], vpn0_q} : ppn;
  assign fault  = bad | ((state_q == L0) ? is_ptr : (ppn[9:0] != 10'd0))
                | (base[21:20] != 2'd0) | (CHECK_A & ~mem_rdata[6]);
  assign pte_d     = fault ? 32'h0 : {base[19:0], 4'h0, mem_rdata[7:0]};
  assign l0_addr_d = {ppn, 12'h000} + {22'h0, vpn0_q, 2'b00};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= IDLE;
      walk_ready_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      pte_q        <= '0;
      vpn0_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (walk_valid) begin
          state_q     <= L1;
          vpn0_q      <= address[21:12];
          mem_valid_q <= 1'b1;
          mem_addr_q  <= {satp[21:0], 12'h000} + {22'h0, address[31:22], 2'b00};
        end
        L1, L0: if (mem_ready) begin
          if (state_q == L1 && is_ptr) begin
            state_q    <= L0;
            mem_addr_q <= l0_addr_d;
          end else begin
            state_q      <= DONE;
            mem_valid_q  <= 1'b0;
            walk_ready_q <= 1'b1;
            pte_q        <= pte_d;
          end
        end
        default: begin
          state_q      <= IDLE;
          walk_ready_q <= 1'b0;
        end
      endcase
    end
  assign walk_ready = walk_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign pte_       = pte_q;
endmodule

// File: tb/tb_sv32_table_walk.sv
// tb_sv32_table_walk: scoreboard bench; a memory responder serves queued PTE reads, a monitor checks each walk result.
module tb_sv32_table_walk;
  logic        clk = 1'b0, resetn = 1'b0, walk_valid = 1'b0, mem_ready = 1'b0;
  logic [31:0] address = '0, satp = '0, mem_rdata = '0;
  logic        walk_ready, mem_valid, na_ready, na_mem_valid;
  logic [31:0] pte_, na_pte;
  logic [33:0] mem_addr, na_mem_addr;
  int total = 0, bad = 0, cyc = 0;
  bit auto_rsp = 1'b1;
  typedef struct {logic [31:0] pte, pte_na; int start, lat;} exp_t;
  typedef struct {logic [33:0] addr; logic [31:0] data; int waits;} rsp_t;
  exp_t sb[$];
  rsp_t rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sv32_table_walk #(.CHECK_A(1'b1)) dut (
    .clk(clk), .resetn(resetn), .walk_valid(walk_valid), .walk_ready(walk_ready),
    .address(address), .satp(satp), .pte_(pte_), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata));
  sv32_table_walk #(.CHECK_A(1'b0)) dut_na (
    .clk(clk), .resetn(resetn), .walk_valid(walk_valid), .walk_ready(na_ready),
    .address(address), .satp(satp), .pte_(na_pte), .mem_valid(na_mem_valid),
    .mem_ready(mem_ready), .mem_addr(na_mem_addr), .mem_rdata(mem_rdata));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: address is compared when the acknowledge is given, so it must have held through the waits.
  initial forever begin
    @(negedge clk);
    if (auto_rsp) begin
      mem_ready = 1'b0;
      if (mem_valid && resetn) begin
        if (rq.size() == 0) chk("unexpected_read", 64'(mem_addr), 64'h0);
        else begin
          rsp_t r;
          r = rq.pop_front();
          repeat (r.waits) @(negedge clk);
          chk("mem_addr", 64'(mem_addr), 64'(r.addr));
          chk("na_mem_addr", 64'(na_mem_addr), 64'(r.addr));
          mem_ready = 1'b1;
          mem_rdata = r.data;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (walk_ready) begin
      if (sb.size() == 0) chk("unexpected_walk_ready", 64'(pte_), 64'h0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pte", 64'(pte_), 64'(e.pte));
        chk("pte_check_a_off", 64'(na_pte), 64'(e.pte_na));
        chk("na_ready", 64'(na_ready), 64'h1);
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        @(negedge clk);
        chk("ready_one_cycle", 64'(walk_ready), 64'h0);
        chk("pte_held", 64'(pte_), 64'(e.pte));
      end
    end
  end

  task automatic rd(input logic [33:0] a, input logic [31:0] d, input int w);
    rq.push_back('{a, d, w});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("walk_timeout", 64'(sb.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic walk(input logic [31:0] a, input logic [31:0] s, input logic [31:0] e,
                      input logic [31:0] ena, input int lat, input bit hold);
    int n = 0;
    walk_valid = 1'b1;
    address = a;
    satp = s;
    sb.push_back('{e, ena, cyc, lat});
    @(negedge clk);
    if (hold) begin
      while (!walk_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      walk_valid = 1'b0;
      @(negedge clk);
      chk("no_restart_from_done", 64'(mem_valid), 64'h0);
    end
    walk_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_walk_ready", 64'(walk_ready), 64'h0);
    chk("rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_pte", 64'(pte_), 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    // 4 KiB page, no waits; L1 PTE 0x20000C01 carries PPN 0x80003
    rd(34'h080000004, 32'h20000C01, 0); rd(34'h080003004, 32'h200010CF, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h800040CF, 32'h800040CF, 3, 1'b0);
    // same walk with memory waits, walk_valid held through DONE
    rd(34'h080000004, 32'h20000C01, 2); rd(34'h080003004, 32'h200010CF, 1);
    walk(32'h00401ABC, 32'h00080000, 32'h800040CF, 32'h800040CF, 6, 1'b1);
    // superpages
    rd(34'h080000004, 32'h200000CF, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h800010CF, 32'h800010CF, 2, 1'b0);
    rd(34'h08000000C, 32'h200000CF, 3);
    walk(32'h00C02000, 32'h00080000, 32'h800020CF, 32'h800020CF, 5, 1'b0);
    // misaligned superpage
    rd(34'h080000004, 32'h200004CF, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h0, 2, 1'b0);
    // L0 V=0, then L0 pointer
    rd(34'h080000004, 32'h20000C01, 0); rd(34'h080003004, 32'h200010CE, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h0, 3, 1'b0);
    rd(34'h080000004, 32'h20000C01, 0); rd(34'h080003004, 32'h00000001, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h0, 3, 1'b0);
    // A=0 leaf: faults only when the accessed check is enabled
    rd(34'h080000004, 32'h20000C01, 0); rd(34'h080003004, 32'h2000108F, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h8000408F, 3, 1'b0);
    // superpage base beyond 32 bits, and W without R at L1
    rd(34'h080000004, 32'h400000CF, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h0, 2, 1'b0);
    rd(34'h080000004, 32'h200000C5, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h0, 32'h0, 2, 1'b0);
    // different root and indices
    rd(34'h012345800, 32'h00008001, 1); rd(34'h000020000, 32'h048D1447, 0);
    walk(32'h80000000, 32'h00012345, 32'h12345047, 32'h12345047, 4, 1'b0);
    // reset while the L0 read is pending, then a stale acknowledge
    auto_rsp = 1'b0;
    walk_valid = 1'b1; address = 32'h00401ABC; satp = 32'h00080000;
    @(negedge clk);
    walk_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h20000C01;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("l0_pending", 64'(mem_valid), 64'h1);
    resetn = 1'b0;
    #1;
    chk("reset_mem_valid", 64'(mem_valid), 64'h0);
    chk("reset_walk_ready", 64'(walk_ready), 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h200010CF;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_mem_valid", 64'(mem_valid), 64'h0);
    chk("late_ready_walk_ready", 64'(walk_ready), 64'h0);
    chk("late_ready_pte", 64'(pte_), 64'h0);
    auto_rsp = 1'b1;
    rd(34'h080000004, 32'h20000C01, 0); rd(34'h080003004, 32'h200010CF, 0);
    walk(32'h00401ABC, 32'h00080000, 32'h800040CF, 32'h800040CF, 3, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
